// File: rtl/flit_inject_if.sv
// flit_inject_if
// Groups the lane and local-source signals of the flit injection stage.
//   net_in_vld / net_in_flit   : incoming network slot on this lane
//   src_vld / src_rdy          : local core valid/ready handshake
//   src_dest / src_data        : local flit destination code and payload
//   net_out_vld / net_out_flit : registered lane output
//   bubble_req                 : asks upstream to leave the next slot empty
//   inj_count                  : saturating count of injected flits
// Modport master drives the inputs of the stage (router/core side),
// modport slave is the injection stage itself.
interface flit_inject_if;
   logic       net_in_vld;
   logic [9:0] net_in_flit;
   logic       src_vld;
   logic       src_rdy;
   logic [2:0] src_dest;
   logic [5:0] src_data;
   logic       net_out_vld;
   logic [9:0] net_out_flit;
   logic       bubble_req;
   logic [7:0] inj_count;

   modport master (
      output net_in_vld, net_in_flit, src_vld, src_dest, src_data,
      input  src_rdy, net_out_vld, net_out_flit, bubble_req, inj_count
   );

   modport slave (
      input  net_in_vld, net_in_flit, src_vld, src_dest, src_data,
      output src_rdy, net_out_vld, net_out_flit, bubble_req, inj_count
   );
endinterface

// File: rtl/flit_inject.sv
// flit_inject
// Local-injection stage of a Chipper router output lane. Local flits are
// queued in a small FIFO and placed into empty network slots; network
// traffic always wins. A starvation monitor raises bubble_req when the
// queue head has been blocked for STARVE_LIMIT consecutive cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : flit_inject_if.slave (lane in/out, local source handshake,
//          bubble_req, inj_count)
// Parameters: DEPTH (power of two, 2..16), STARVE_LIMIT (>= 2),
//             CW (starvation counter width, must hold STARVE_LIMIT).
// Optional feature: define FLIT_INJECT_GOLDEN_EN to mark flits injected
// while starving as golden (bit 9 set) so downstream sorters favour them.
module flit_inject #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int CW           = 4
) (
   input logic         clk,
   input logic         rst,
   flit_inject_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STARVE = 2'd2
   } state_t;

   logic [8:0]    mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          blocked;
   logic [8:0]    head;
   logic          golden;
   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The extra pointer bit tells a full FIFO (same slot, different lap)
   // from an empty one (same slot, same lap).
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push    = bus.src_vld && !full;
   assign pop     = !bus.net_in_vld && !empty;
   assign blocked = bus.net_in_vld && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   assign bus.src_rdy = !full;

`ifdef FLIT_INJECT_GOLDEN_EN
   assign golden = (state_q == STARVE);
`else
   assign golden = 1'b0;
`endif

   // Storage array. Contents need no reset because the pointers alone
   // decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {1'b0, bus.src_dest, bus.src_data};
      end
   end

   // FIFO pointers; both wrap naturally modulo 2*DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   // Output slot: a network flit passes through untouched, otherwise the
   // queue head fills the empty slot. With nothing to send the flit
   // register keeps its last value and only the valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.net_out_vld  <= 1'b0;
         bus.net_out_flit <= '0;
         bus.inj_count    <= '0;
      end else begin
         if (bus.net_in_vld) begin
            bus.net_out_vld  <= 1'b1;
            bus.net_out_flit <= bus.net_in_flit;
         end else if (!empty) begin
            bus.net_out_vld  <= 1'b1;
            bus.net_out_flit <= {golden, head[8:0]};
         end else begin
            bus.net_out_vld  <= 1'b0;
         end
         if (pop && (bus.inj_count != 8'hFF)) begin
            bus.inj_count <= bus.inj_count + 8'd1;
         end
      end
   end

   // Starvation state register. bubble_req is registered from the next
   // state so it is high exactly for the cycles spent in STARVE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         bus.bubble_req <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         bus.bubble_req <= (state_d == STARVE);
      end
   end

   // Next-state logic. The first blocked cycle already counts, so the
   // move to STARVE happens on the STARVE_LIMIT-th consecutive blocked
   // cycle. Once starving the counter is frozen until the head leaves.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (blocked) begin
               state_d = WAIT;
               cnt_d   = CW'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (blocked) begin
               if (cnt_q == CW'(STARVE_LIMIT - 1)) begin
                  state_d = STARVE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         STARVE: begin
            if (!blocked) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_flit_inject.sv
// tb_flit_inject
// Directed bench for flit_inject (DEPTH=4, STARVE_LIMIT=8). A vector table
// covers reset-then-inject and pass-through priority; hand-written
// sequences cover a full FIFO, starvation/bubble, steady push+pop and an
// asynchronous mid-operation reset. Honours FLIT_INJECT_GOLDEN_EN.
module tb_flit_inject;

   typedef struct {
      logic       nvld;
      logic [9:0] nflit;
      logic       svld;
      logic [2:0] sdest;
      logic [5:0] sdata;
      logic       erdy;
      logic       evld;
      logic [9:0] eflit;
      logic       ebub;
      logic [7:0] einj;
   } vec_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   vec_t vecs[6];

   flit_inject_if bus();

   flit_inject #(.DEPTH(4), .STARVE_LIMIT(8), .CW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, let the DUT take the edge, and return
   // 1 time unit after the edge so outputs can be sampled safely.
   task automatic applyStimulus(input logic nvld, input logic [9:0] nflit,
                                input logic svld, input logic [2:0] sdest,
                                input logic [5:0] sdata);
      bus.net_in_vld  = nvld;
      bus.net_in_flit = nflit;
      bus.src_vld     = svld;
      bus.src_dest    = sdest;
      bus.src_data    = sdata;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [9:0] act,
                              input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic erdy, input logic evld,
                           input logic [9:0] eflit, input logic ebub,
                           input logic [7:0] einj);
      checkOutput({tag, " src_rdy"}, {9'd0, bus.src_rdy}, {9'd0, erdy});
      checkOutput({tag, " net_out_vld"}, {9'd0, bus.net_out_vld}, {9'd0, evld});
      checkOutput({tag, " net_out_flit"}, bus.net_out_flit, eflit);
      checkOutput({tag, " bubble_req"}, {9'd0, bus.bubble_req}, {9'd0, ebub});
      checkOutput({tag, " inj_count"}, {2'd0, bus.inj_count}, {2'd0, einj});
   endtask

   initial begin
      logic [9:0] gold_flit;
      errors = 0;
      checks = 0;

      // Reset-then-inject and pass-through priority, expected values
      // sampled just after each clock edge.
      vecs[0] = '{1'b0, 10'h000, 1'b1, 3'd2, 6'h15, 1'b1, 1'b0, 10'h000, 1'b0, 8'd0};
      vecs[1] = '{1'b0, 10'h000, 1'b0, 3'd0, 6'h00, 1'b1, 1'b1, 10'h095, 1'b0, 8'd1};
      vecs[2] = '{1'b1, 10'h2C3, 1'b1, 3'd5, 6'h2A, 1'b1, 1'b1, 10'h2C3, 1'b0, 8'd1};
      vecs[3] = '{1'b1, 10'h1FF, 1'b0, 3'd0, 6'h00, 1'b1, 1'b1, 10'h1FF, 1'b0, 8'd1};
      vecs[4] = '{1'b0, 10'h000, 1'b0, 3'd0, 6'h00, 1'b1, 1'b1, 10'h16A, 1'b0, 8'd2};
      vecs[5] = '{1'b0, 10'h000, 1'b0, 3'd0, 6'h00, 1'b1, 1'b0, 10'h16A, 1'b0, 8'd2};

`ifdef FLIT_INJECT_GOLDEN_EN
      gold_flit = 10'h3FF;
`else
      gold_flit = 10'h1FF;
`endif

      rst             = 1'b1;
      bus.net_in_vld  = 1'b0;
      bus.net_in_flit = '0;
      bus.src_vld     = 1'b0;
      bus.src_dest    = '0;
      bus.src_data    = '0;
      repeat (2) @(posedge clk);
      #1;
      checkAll("reset", 1'b1, 1'b0, 10'h000, 1'b0, 8'd0);
      rst = 1'b0;
      #1;
      checkOutput("post-reset src_rdy", {9'd0, bus.src_rdy}, 10'd1);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].nvld, vecs[i].nflit, vecs[i].svld,
                       vecs[i].sdest, vecs[i].sdata);
         checkAll($sformatf("vec%0d", i), vecs[i].erdy, vecs[i].evld,
                  vecs[i].eflit, vecs[i].ebub, vecs[i].einj);
      end

      // FIFO full with the lane busy, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 10'h3C0, 1'b1, 3'd1, 6'(i));
      end
      checkAll("full", 1'b0, 1'b1, 10'h3C0, 1'b0, 8'd2);
      applyStimulus(1'b1, 10'h3C0, 1'b1, 3'd1, 6'd5);
      checkOutput("full 5th rdy", {9'd0, bus.src_rdy}, 10'd0);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b0, 10'h000, 1'b0, 3'd0, 6'd0);
         checkAll($sformatf("drain%0d", i), 1'b1, 1'b1, 10'h040 | 10'(i),
                  1'b0, 8'(2 + i));
      end
      applyStimulus(1'b0, 10'h000, 1'b0, 3'd0, 6'd0);
      checkOutput("drain empty vld", {9'd0, bus.net_out_vld}, 10'd0);

      // Starvation: one queued flit, lane busy for 10 cycles.
      applyStimulus(1'b1, 10'h155, 1'b1, 3'd7, 6'h3F);
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b1, 10'h155, 1'b0, 3'd0, 6'd0);
         checkOutput($sformatf("starve bubble k%0d", k),
                     {9'd0, bus.bubble_req}, {9'd0, (k >= 8)});
      end
      applyStimulus(1'b0, 10'h000, 1'b0, 3'd0, 6'd0);
      checkAll("starve inject", 1'b1, 1'b1, gold_flit, 1'b0, 8'd7);
      applyStimulus(1'b0, 10'h000, 1'b0, 3'd0, 6'd0);
      checkAll("starve after", 1'b1, 1'b0, gold_flit, 1'b0, 8'd7);

      // Steady push and pop at occupancy 2.
      applyStimulus(1'b1, 10'h155, 1'b1, 3'd2, 6'h21);
      applyStimulus(1'b1, 10'h155, 1'b1, 3'd3, 6'h22);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 10'h000, 1'b1, 3'd4, 6'h30 + 6'(i));
         checkAll($sformatf("pushpop%0d", i), 1'b1, 1'b1,
                  (i == 0) ? 10'h0A1 : (i == 1) ? 10'h0E2 : 10'h130 + 10'(i - 2),
                  1'b0, 8'(8 + i));
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 10'h000, 1'b0, 3'd0, 6'd0);
         checkAll($sformatf("pushpop drain%0d", i), 1'b1, 1'b1,
                  10'h134 + 10'(i), 1'b0, 8'(14 + i));
      end
      applyStimulus(1'b0, 10'h000, 1'b0, 3'd0, 6'd0);
      checkOutput("pushpop empty vld", {9'd0, bus.net_out_vld}, 10'd0);

      // Mid-operation asynchronous reset with 3 queued flits and bubble_req.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 10'h2AA, 1'b1, 3'd6, 6'(i));
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 10'h2AA, 1'b0, 3'd0, 6'd0);
      end
      checkAll("pre-reset", 1'b1, 1'b1, 10'h2AA, 1'b1, 8'd15);
      #2;
      rst = 1'b1;
      #1;
      checkAll("async reset", 1'b1, 1'b0, 10'h000, 1'b0, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 10'h000, 1'b0, 3'd0, 6'd0);
      checkAll("after reset", 1'b1, 1'b0, 10'h000, 1'b0, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/flit_inject.md
Name: flit_inject

Overview:
Local-injection stage of a Chipper router output port. It sits after the 2-input deflection sorter on one output lane. It accepts flits from the local core through a valid/ready FIFO and places them into empty network slots on that lane. Network traffic always has priority; a starvation monitor requests a bubble from upstream when local traffic waits too long.

Parameters:
DEPTH, 4, local FIFO depth in flits; power of two, 2..16
STARVE_LIMIT, 8, consecutive blocked cycles before a bubble is requested
CW, 4, width of the starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
net_in_vld  in  1  network slot on this lane is occupied
net_in_flit  in  10  network flit: [9] golden, [8:6] dest code, [5:0] payload
src_vld  in  1  local core presents a flit
src_rdy  out  1  FIFO can accept a flit
src_dest  in  3  local flit destination code
src_data  in  6  local flit payload
net_out_vld  out  1  registered lane output valid
net_out_flit  out  10  registered lane output flit
bubble_req  out  1  asks upstream to leave the next slot empty
inj_count  out  8  saturating count of flits injected since reset

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - net_out_vld=0, net_out_flit=0, bubble_req=0, inj_count=0.
  - FIFO is empty, so src_rdy=1 once rst deasserts.
  - State=IDLE, starvation counter=0.
- Enqueue:
  - A flit is written when src_vld & src_rdy at the clock edge.
  - Stored word is {1'b0, src_dest, src_data}.
  - src_rdy = !full, purely from registered FIFO state.
  - Simultaneous enqueue and dequeue while full is not allowed, because src_rdy=0.
  - Simultaneous enqueue and dequeue at any other occupancy keeps occupancy unchanged.
- Output slot, latency 1, decided every cycle:
  - If net_in_vld: net_out <= {1, net_in_flit}. This is a bit-exact pass-through, and no dequeue happens.
  - Else if FIFO not empty: net_out <= {1, head}, pop the head, and increment inj_count (saturates at 255).
  - Else: net_out_vld <= 0 and net_out_flit holds its previous value.
- Flit ordering: FIFO order is preserved and flits are never dropped or duplicated.
- Pointers wrap modulo DEPTH. An extra occupancy bit distinguishes full from empty.
- State machine:
  - IDLE: FIFO empty, or head injected this cycle. Moves to WAIT when FIFO is non-empty and net_in_vld=1.
  - WAIT: the counter increments each blocked cycle. On injection, go to IDLE and clear the counter. When the counter reaches STARVE_LIMIT-1 while still blocked, go to STARVE.
  - STARVE: bubble_req=1, registered and asserted in the cycle after entry. Stays in STARVE until the head is injected, then goes to IDLE with the counter cleared. bubble_req deasserts in the cycle after the injection.
- Upstream may ignore bubble_req. If it does, the block stays in STARVE, and the counter holds and does not wrap.
- Reset asserted mid-operation clears FIFO contents, state, and outputs immediately. A flit in flight on net_out is lost; this is acceptable.

Optional Feature:
Macro: FLIT_INJECT_GOLDEN_EN.
- Defined: a flit injected while in STARVE goes out with bit [9]=1 (golden), so downstream sorters favour it. Flits injected from IDLE or WAIT keep [9]=0.
- Not defined: injected flits always carry [9]=0. bubble_req behaviour is identical in both builds.

Test Plan:
1. Reset then idle lane: after rst, src_rdy=1. Push dest=3'b010, data=6'h15 with net_in_vld=0. The next cycle gives net_out_vld=1, net_out_flit=10'h095, and inj_count=1.
2. Pass-through priority: net_in_vld=1 with flit 10'h2C3 while the FIFO holds one flit. Output is 10'h2C3 one cycle later and the FIFO count stays unchanged.
3. FIFO full: with DEPTH=4 and the lane constantly busy, push 4 flits. src_rdy drops to 0 and a 5th src_vld is not accepted. Release the lane: 4 flits exit in order on consecutive cycles and src_rdy returns to 1.
4. Starvation: one queued flit with the lane busy for 10 cycles. bubble_req rises on the cycle after 8 blocked cycles. Drop net_in_vld for one cycle: the flit is injected, with bit9=1 only if FLIT_INJECT_GOLDEN_EN is defined. bubble_req falls the following cycle.
5. Simultaneous push and pop: at 2 flits occupancy on an empty lane, push each cycle for 6 cycles. Occupancy stays at 2 and output order matches input order.
6. Mid-operation reset: assert rst asynchronously with 3 queued flits and bubble_req=1. All outputs zero immediately and the FIFO is empty after release.
